// File: rtl/uart_flit_rx.sv
// uart_flit_rx: assembles FLIT_BYTES UART frames into one flit behind a valid/ready handshake; define UART_PARITY_EN for even-parity frames and parity_err
module uart_flit_rx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FLIT_BYTES = 16,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic                    cpuclk,
  input  logic                    rst,
  input  logic                    uart_rx,
  output logic [8*FLIT_BYTES-1:0] flit_rx,
  output logic                    flit_rx_valid,
  input  logic                    flit_rx_ready,
  output logic                    framing_err,
  output logic                    timeout_err,
  output logic                    overflow_err,
`ifdef UART_PARITY_EN
  output logic                    parity_err,
`endif
  output logic                    busy
);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(FLIT_BYTES + 1);
  localparam int OW = $clog2(TIMEOUT_BITS + 1);
  localparam int FW = 8 * FLIT_BYTES;
  localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] T_FULL = TW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] C_LAST = CW'(FLIT_BYTES - 1);
  localparam logic [OW-1:0] O_LAST = OW'(TIMEOUT_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t state_q, state_d;
  logic sync1_q, sync2_q;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] shift_q, shift_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [OW-1:0] to_q, to_d;
  logic [FW-1:0] asm_q, asm_d, flit_q, flit_d;
  logic valid_q, valid_d, ferr_q, ferr_d, terr_q, terr_d, oerr_q, oerr_d;
  logic rx, frame_bad;

  assign rx = sync2_q;
`ifdef UART_PARITY_EN
  logic perr_q, perr_d, par_q, par_d;
  assign frame_bad = !rx || perr_q;
  assign parity_err = par_q;
`else
  assign frame_bad = !rx;
`endif
  assign flit_rx = flit_q;
  assign flit_rx_valid = valid_q;
  assign framing_err = ferr_q;
  assign timeout_err = terr_q;
  assign overflow_err = oerr_q;
  assign busy = (cnt_q != '0) || (state_q != IDLE);

  // frame FSM, flit assembly, inter-byte timeout and output register update
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    idx_d = idx_q;
    shift_d = shift_q;
    cnt_d = cnt_q;
    to_d = to_q;
    asm_d = asm_q;
    flit_d = flit_q;
    valid_d = valid_q && !flit_rx_ready;
    ferr_d = 1'b0;
    terr_d = 1'b0;
    oerr_d = 1'b0;
`ifdef UART_PARITY_EN
    perr_d = perr_q;
    par_d = 1'b0;
`endif
    case (state_q)
      IDLE: if (!rx) begin
        state_d = START;
        timer_d = T_HALF;
      end else if (cnt_q != '0) begin
        timer_d = timer_q - 1'b1;
        if (timer_q == '0) begin
          timer_d = T_FULL;
          to_d = (to_q == O_LAST) ? '0 : to_q + 1'b1;
          cnt_d = (to_q == O_LAST) ? '0 : cnt_q;
          terr_d = (to_q == O_LAST);
        end
      end
      START: if (timer_q == '0) begin
        state_d = rx ? IDLE : DATA;
        timer_d = T_FULL;
        idx_d = '0;
      end else timer_d = timer_q - 1'b1;
      DATA: if (timer_q == '0) begin
        shift_d = {rx, shift_q[7:1]};
        timer_d = T_FULL;
        idx_d = idx_q + 1'b1;
`ifdef UART_PARITY_EN
        state_d = (idx_q == 3'd7) ? PARITY : DATA;
`else
        state_d = (idx_q == 3'd7) ? STOP : DATA;
`endif
      end else timer_d = timer_q - 1'b1;
`ifdef UART_PARITY_EN
      PARITY: if (timer_q == '0) begin
        perr_d = rx ^ (^shift_q);
        timer_d = T_FULL;
        state_d = STOP;
      end else timer_d = timer_q - 1'b1;
`endif
      STOP: if (timer_q == '0) begin
        state_d = IDLE;
        timer_d = T_FULL;
        to_d = '0;
        ferr_d = !rx;
`ifdef UART_PARITY_EN
        perr_d = 1'b0;
        par_d = perr_q;
`endif
        if (frame_bad) cnt_d = '0;
        else begin
          asm_d[{cnt_q, 3'b000} +: 8] = shift_q;
          cnt_d = (cnt_q == C_LAST) ? '0 : cnt_q + 1'b1;
          if (cnt_q == C_LAST) begin
            if (!valid_q || flit_rx_ready) begin
              flit_d = asm_d;
              valid_d = 1'b1;
            end else oerr_d = 1'b1;
          end
        end
      end else timer_d = timer_q - 1'b1;
      default: state_d = IDLE;
    endcase
  end

  // state registers; synchroniser flops reset to the idle line level
  always_ff @(posedge cpuclk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= IDLE;
      timer_q <= '0;
      idx_q <= '0;
      shift_q <= '0;
      cnt_q <= '0;
      to_q <= '0;
      asm_q <= '0;
      flit_q <= '0;
      valid_q <= 1'b0;
      ferr_q <= 1'b0;
      terr_q <= 1'b0;
      oerr_q <= 1'b0;
`ifdef UART_PARITY_EN
      perr_q <= 1'b0;
      par_q <= 1'b0;
`endif
    end else begin
      sync1_q <= uart_rx;
      sync2_q <= sync1_q;
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q <= idx_d;
      shift_q <= shift_d;
      cnt_q <= cnt_d;
      to_q <= to_d;
      asm_q <= asm_d;
      flit_q <= flit_d;
      valid_q <= valid_d;
      ferr_q <= ferr_d;
      terr_q <= terr_d;
      oerr_q <= oerr_d;
`ifdef UART_PARITY_EN
      perr_q <= perr_d;
      par_q <= par_d;
`endif
    end
  end
endmodule

// File: tb/tb_uart_flit_rx.sv
// tb_uart_flit_rx: directed UART frame stimulus for uart_flit_rx at 8 clocks per bit
module tb_uart_flit_rx;
  localparam int CPB = 8;
  logic cpuclk = 1'b0;
  logic rst = 1'b1;
  logic uart_rx = 1'b1;
  logic flit_rx_ready = 1'b0;
  logic [127:0] flit_rx;
  logic flit_rx_valid, framing_err, timeout_err, overflow_err, busy;
  logic [127:0] last_flit = '0;
  int n_chk = 0;
  int n_pass = 0;
  int fe_n = 0;
  int te_n = 0;
  int oe_n = 0;
  int vl_n = 0;
  int f0, t0, o0, v0;
`ifdef UART_PARITY_EN
  logic parity_err;
  logic par_flip = 1'b0;
  int pe_n = 0;
  int p0;
`endif

  always #5 cpuclk = ~cpuclk;

  uart_flit_rx #(.CLKS_PER_BIT(CPB), .FLIT_BYTES(16), .TIMEOUT_BITS(32)) dut (
    .cpuclk(cpuclk),
    .rst(rst),
    .uart_rx(uart_rx),
    .flit_rx(flit_rx),
    .flit_rx_valid(flit_rx_valid),
    .flit_rx_ready(flit_rx_ready),
    .framing_err(framing_err),
    .timeout_err(timeout_err),
    .overflow_err(overflow_err),
`ifdef UART_PARITY_EN
    .parity_err(parity_err),
`endif
    .busy(busy)
  );

  // pulse counters and last-seen flit, sampled mid-cycle
  always @(negedge cpuclk) begin
    if (framing_err) fe_n++;
    if (timeout_err) te_n++;
    if (overflow_err) oe_n++;
`ifdef UART_PARITY_EN
    if (parity_err) pe_n++;
`endif
    if (flit_rx_valid) begin
      vl_n++;
      last_flit = flit_rx;
    end
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1, input bit lat = 1'b0);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge cpuclk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge cpuclk);
    end
`ifdef UART_PARITY_EN
    uart_rx = (^b) ^ par_flip;
    repeat (CPB) @(negedge cpuclk);
`endif
    uart_rx = stop;
    if (lat) begin
      repeat (CPB - 2) @(negedge cpuclk);
      check("latency_before", flit_rx_valid, 0);
      @(negedge cpuclk);
      check("latency_at", flit_rx_valid, 1);
      @(negedge cpuclk);
    end else repeat (CPB) @(negedge cpuclk);
  endtask

  task automatic send_flit(input logic [7:0] base, input bit lat = 1'b0);
    for (int i = 0; i < 16; i++) send_byte(base + 8'(i), 1'b1, lat && i == 15);
  endtask

  function automatic logic [127:0] ramp(input logic [7:0] base);
    logic [127:0] f;
    for (int i = 0; i < 16; i++) f[8*i +: 8] = base + 8'(i);
    return f;
  endfunction

  initial begin
    repeat (3) @(negedge cpuclk);
    check("rst_flit", flit_rx, 0);
    check("rst_valid", flit_rx_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_errs", fe_n + te_n + oe_n, 0);
    rst = 1'b0;
    repeat (4) @(negedge cpuclk);

    flit_rx_ready = 1'b1;
    v0 = vl_n;
    send_flit(8'h00, 1'b1);
    check("t1_flit", last_flit, 128'h0F0E0D0C0B0A09080706050403020100);
    check("t1_valid_cycles", vl_n - v0, 1);
    check("t1_errs", fe_n + te_n + oe_n, 0);
    check("t1_busy", busy, 0);

    flit_rx_ready = 1'b0;
    send_flit(8'h10, 1'b1);
    check("t2_a_valid", flit_rx_valid, 1);
    check("t2_a_flit", flit_rx, 128'h1F1E1D1C1B1A19181716151413121110);
    o0 = oe_n;
    send_flit(8'h20);
    check("t2_overflow", oe_n - o0, 1);
    check("t2_a_held", flit_rx, 128'h1F1E1D1C1B1A19181716151413121110);
    check("t2_still_valid", flit_rx_valid, 1);
    flit_rx_ready = 1'b1;
    @(negedge cpuclk);
    check("t2_accepted", flit_rx_valid, 0);
    repeat (20) @(negedge cpuclk);
    check("t2_no_b", flit_rx_valid, 0);
    check("t2_last", last_flit, 128'h1F1E1D1C1B1A19181716151413121110);

    f0 = fe_n;
    v0 = vl_n;
    for (int i = 0; i < 5; i++) send_byte(8'h50 + 8'(i));
    send_byte(8'h55, 1'b0);
    uart_rx = 1'b1;
    repeat (2 * CPB) @(negedge cpuclk);
    check("t3_framing", fe_n - f0, 1);
    check("t3_busy_cleared", busy, 0);
    for (int i = 0; i < 16; i++) send_byte(8'hAA);
    check("t3_flit", last_flit, {16{8'hAA}});
    check("t3_valid_cycles", vl_n - v0, 1);
    check("t3_framing_once", fe_n - f0, 1);

    t0 = te_n;
    for (int i = 0; i < 3; i++) send_byte(8'hC0 + 8'(i));
    repeat (250) @(negedge cpuclk);
    check("t4_busy_before", busy, 1);
    check("t4_no_timeout_yet", te_n - t0, 0);
    repeat (10) @(negedge cpuclk);
    check("t4_timeout", te_n - t0, 1);
    check("t4_busy_after", busy, 0);
    repeat (60) @(negedge cpuclk);
    send_flit(8'h30);
    check("t4_flit", last_flit, ramp(8'h30));
    check("t4_timeout_once", te_n - t0, 1);

    f0 = fe_n;
    t0 = te_n;
    o0 = oe_n;
    v0 = vl_n;
    uart_rx = 1'b0;
    repeat (2) @(negedge cpuclk);
    uart_rx = 1'b1;
    repeat (2 * CPB) @(negedge cpuclk);
    check("t5_glitch_busy", busy, 0);
    check("t5_glitch_errs", (fe_n - f0) + (te_n - t0) + (oe_n - o0), 0);
    check("t5_glitch_valid", vl_n - v0, 0);
    send_flit(8'h40);
    check("t5_flit", last_flit, ramp(8'h40));
    check("t5_valid_cycles", vl_n - v0, 1);

    for (int i = 0; i < 6; i++) send_byte(8'h60 + 8'(i));
    uart_rx = 1'b0;
    repeat (CPB) @(negedge cpuclk);
    uart_rx = 1'b1;
    repeat (3 * CPB) @(negedge cpuclk);
    rst = 1'b1;
    @(negedge cpuclk);
    check("t6_rst_flit", flit_rx, 0);
    check("t6_rst_valid", flit_rx_valid, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_errs", {framing_err, timeout_err, overflow_err}, 0);
    rst = 1'b0;
    repeat (2 * CPB) @(negedge cpuclk);
    send_flit(8'h70);
    check("t6_flit", last_flit, ramp(8'h70));

`ifdef UART_PARITY_EN
    p0 = pe_n;
    f0 = fe_n;
    send_byte(8'h91);
    send_byte(8'h92);
    par_flip = 1'b1;
    send_byte(8'h01);
    par_flip = 1'b0;
    check("t7_parity", pe_n - p0, 1);
    check("t7_busy", busy, 0);
    check("t7_no_framing", fe_n - f0, 0);
    send_flit(8'h80);
    check("t7_flit", last_flit, ramp(8'h80));
    check("t7_parity_once", pe_n - p0, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
